// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - flit field positions and write-side FSM encodings
package router_pkg;

   localparam int BOP_BIT   = 69;
   localparam int EOP_BIT   = 68;
   localparam int DATA_MSB  = 67;
   localparam int DATA_LSB  = 4;
   localparam int VALID_MSB = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PKT  = 2'd1,
      DROP = 2'd2
   } wr_state_t;

endpackage

// File: rtl/flit_ram.sv
// rtl/flit_ram.sv - simple dual-port flit RAM, synchronous write, asynchronous read
module flit_ram #(
   parameter int DATA_WIDTH = 70,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/tx_pkt_buffer.sv
// rtl/tx_pkt_buffer.sv - store-and-forward transmit packet buffer
// Packets become visible to the MAC side only once their eop flit is committed.
module tx_pkt_buffer
   import router_pkg::*;
#(
   parameter int DATA_WIDTH = 70,
   parameter int ADDR_WIDTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_val,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] data_router,
   output logic                  val,
   input  logic                  ack,
   output logic [CNT_WIDTH-1:0]  drop_cnt
);

   localparam logic [ADDR_WIDTH:0] DEPTH   = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

   wr_state_t r_state, w_next;

   logic [ADDR_WIDTH:0]   r_rd_ptr, r_wr_ptr, r_commit_ptr, r_pkt_count;
   logic [CNT_WIDTH-1:0]  r_drop_cnt;
   logic                  w_full, w_pkt_empty, w_accept, w_bop, w_eop;
   logic                  w_wr_en, w_rollback, w_commit, w_overflow, w_drop_inc;
   logic                  w_rd_fire, w_pkt_dec;
   logic [ADDR_WIDTH:0]   w_wr_addr, w_wr_next;
   logic [DATA_WIDTH-1:0] w_rd_data;

   assign w_full      = (r_wr_ptr - r_rd_ptr) == DEPTH;
   assign w_pkt_empty = (r_pkt_count == '0);
   assign w_accept    = in_val & in_ready;
   assign w_bop       = in_data[BOP_BIT];
   assign w_eop       = in_data[EOP_BIT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (w_accept && w_bop && !w_eop) w_next = PKT;
         PKT: begin
            if (w_accept) begin
               if (w_full)     w_next = DROP;
               else if (w_eop) w_next = IDLE;
            end
         end
         DROP: begin
            if (w_accept) begin
               if (w_bop && !w_full) w_next = w_eop ? IDLE : PKT;
               else if (w_eop)       w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready   = 1'b1;
      w_wr_en    = 1'b0;
      w_rollback = 1'b0;
      w_commit   = 1'b0;
      w_overflow = 1'b0;
      w_drop_inc = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = !w_full;
            if (w_accept && w_bop) begin
               w_wr_en  = 1'b1;
               w_commit = w_eop;
            end
         end
         PKT: begin
            in_ready = !w_full || w_pkt_empty;
            if (w_accept) begin
               if (w_full) begin
                  w_overflow = 1'b1;
                  w_drop_inc = 1'b1;
               end else begin
                  // A new bop here means the previous packet lost its eop.
                  w_wr_en    = 1'b1;
                  w_rollback = w_bop;
                  w_drop_inc = w_bop;
                  w_commit   = w_eop;
               end
            end
         end
         DROP: begin
            in_ready = 1'b1;
            if (w_accept && w_bop && !w_full) begin
               w_wr_en  = 1'b1;
               w_commit = w_eop;
            end
         end
         default: in_ready = 1'b1;
      endcase
   end

   assign w_wr_addr = w_rollback ? r_commit_ptr : r_wr_ptr;
   assign w_wr_next = w_wr_addr + PTR_ONE;

   flit_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_flit_ram (
      .clk       (clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (w_wr_addr[ADDR_WIDTH-1:0]),
      .i_wr_data (in_data),
      .i_rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
      .o_rd_data (w_rd_data)
   );

   assign w_rd_fire = val & ack;
   assign w_pkt_dec = w_rd_fire & w_rd_data[EOP_BIT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr     <= '0;
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
         r_pkt_count  <= '0;
         r_drop_cnt   <= '0;
      end else begin
         if (w_overflow)   r_wr_ptr <= r_commit_ptr;
         else if (w_wr_en) r_wr_ptr <= w_wr_next;
         if (w_commit)     r_commit_ptr <= w_wr_next;
         if (w_rd_fire)    r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_commit, w_pkt_dec})
            2'b10:   r_pkt_count <= r_pkt_count + PTR_ONE;
            2'b01:   r_pkt_count <= r_pkt_count - PTR_ONE;
            default: r_pkt_count <= r_pkt_count;
         endcase
         if (w_drop_inc && r_drop_cnt != {CNT_WIDTH{1'b1}})
            r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
      end
   end

   assign val         = !w_pkt_empty;
   assign data_router = val ? w_rd_data : '0;
   assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_tx_pkt_buffer.sv
// tb/tb_tx_pkt_buffer.sv - scoreboard bench for tx_pkt_buffer
module tb_tx_pkt_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [69:0] in_data;
   logic        in_val;
   logic        in_ready;
   logic [69:0] data_router;
   logic        val;
   logic        ack;
   logic [15:0] drop_cnt;

   int total = 0;
   int bad   = 0;
   logic [69:0] sb [$];

   always #5 clk = ~clk;

   tx_pkt_buffer dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_val      (in_val),
      .in_ready    (in_ready),
      .data_router (data_router),
      .val         (val),
      .ack         (ack),
      .drop_cnt    (drop_cnt)
   );

   function automatic logic [69:0] mk(input logic b, input logic e,
                                      input logic [63:0] p, input logic [3:0] v);
      return {b, e, p, v};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic chk70(input string name, input logic [69:0] act, input logic [69:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Returns 1 ns after the edge on which the flit was accepted.
   task automatic send(input logic [69:0] d, input bit exp_out);
      int n;
      n = 0;
      in_data = d;
      in_val  = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready=0 required 1");
         in_val = 1'b0;
         return;
      end
      if (exp_out) sb.push_back(d);
      @(posedge clk);
      #1;
      in_val = 1'b0;
   endtask

   always @(negedge clk) begin
      logic [69:0] exp_flit;
      if (!rst) begin
         if (val && ack) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_extra: got %h required no flit", data_router);
            end else begin
               exp_flit = sb.pop_front();
               chk70("sb_flit", data_router, exp_flit);
            end
         end else if (!val) begin
            chk70("idle_zero", data_router, '0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run still active at time limit");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      rst     = 1'b1;
      in_val  = 1'b0;
      in_data = '0;
      ack     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_val", val, 0);
      chk70("rst_data", data_router, '0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_ready", in_ready, 1);

      // single-flit packet
      send(mk(1, 1, 64'hA5A5_0000_0000_5A5A, 4'hF), 1);
      chk("t1_val", val, 1);
      chk70("t1_data", data_router, mk(1, 1, 64'hA5A5_0000_0000_5A5A, 4'hF));
      ack = 1'b1;
      @(posedge clk);
      #1;
      chk("t1_val_after", val, 0);
      chk("t1_sb_empty", sb.size(), 0);

      // store-and-forward with ack held high
      for (int i = 0; i < 4; i++) begin
         send(mk(i == 0, i == 3, 64'h2000_0000_0000_0000 + 64'(i), 4'hF), 1);
         chk("t2_val", val, (i == 3) ? 1 : 0);
      end
      for (int i = 0; i < 4; i++) begin
         chk("t2_stream", val, 1);
         @(posedge clk);
         #1;
      end
      chk("t2_val_end", val, 0);
      chk("t2_sb_empty", sb.size(), 0);

      // missing eop: A is rolled back, B delivered
      ack = 1'b0;
      send(mk(1, 0, 64'h3A00_0000_0000_0000, 4'hF), 0);
      send(mk(0, 0, 64'h3A00_0000_0000_0001, 4'hF), 0);
      send(mk(1, 0, 64'h3B00_0000_0000_0000, 4'hF), 1);
      send(mk(0, 0, 64'h3B00_0000_0000_0001, 4'hF), 1);
      send(mk(0, 1, 64'h3B00_0000_0000_0002, 4'h3), 1);
      chk("t3_drop", drop_cnt, 1);
      chk("t3_val", val, 1);
      ack = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("t3_val_end", val, 0);
      chk("t3_sb_empty", sb.size(), 0);

      // overflow: 20-flit packet into a 16-deep buffer
      ack = 1'b0;
      for (int i = 0; i < 20; i++) begin
         chk("t4_ready", in_ready, 1);
         chk("t4_no_val", val, 0);
         send(mk(i == 0, i == 19, 64'h4000_0000_0000_0000 + 64'(i), 4'hF), 0);
      end
      chk("t4_drop", drop_cnt, 2);
      chk("t4_val", val, 0);
      ack = 1'b1;
      send(mk(1, 0, 64'h4100_0000_0000_0000, 4'hF), 1);
      send(mk(0, 1, 64'h4100_0000_0000_0001, 4'h1), 1);
      repeat (3) @(posedge clk);
      #1;
      chk("t4_val_end", val, 0);
      chk("t4_sb_empty", sb.size(), 0);

      // backpressure: fill with four 4-flit packets
      ack = 1'b0;
      for (int p = 0; p < 4; p++)
         for (int i = 0; i < 4; i++)
            send(mk(i == 0, i == 3, 64'h5000_0000_0000_0000 + 64'(p * 16 + i), 4'hF), 1);
      for (int i = 0; i < 3; i++) begin
         chk("t5_full_ready", in_ready, 0);
         chk("t5_val", val, 1);
         @(posedge clk);
         #1;
      end
      ack = 1'b1;
      send(mk(1, 0, 64'h5100_0000_0000_0000, 4'hF), 1);
      send(mk(0, 1, 64'h5100_0000_0000_0001, 4'hF), 1);
      repeat (20) @(posedge clk);
      #1;
      chk("t5_val_end", val, 0);
      chk("t5_ready_end", in_ready, 1);
      chk("t5_sb_empty", sb.size(), 0);
      chk("t5_drop", drop_cnt, 2);

      // reset while a packet is visible and another is mid-write
      ack = 1'b0;
      send(mk(1, 1, 64'h6000_0000_0000_0000, 4'hF), 0);
      send(mk(1, 0, 64'h6100_0000_0000_0000, 4'hF), 0);
      in_data = mk(0, 0, 64'h6100_0000_0000_0001, 4'hF);
      in_val  = 1'b1;
      chk("t6_val_pre", val, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_val", val, 0);
      chk70("t6_rst_data", data_router, '0);
      chk("t6_rst_drop", drop_cnt, 0);
      sb.delete();
      in_val = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("t6_ready", in_ready, 1);
      chk("t6_val_idle", val, 0);
      ack = 1'b1;
      send(mk(1, 0, 64'h6200_0000_0000_0000, 4'hF), 1);
      send(mk(0, 0, 64'h6200_0000_0000_0001, 4'hF), 1);
      send(mk(0, 1, 64'h6200_0000_0000_0002, 4'h7), 1);
      repeat (4) @(posedge clk);
      #1;
      chk("t6_val_end", val, 0);
      chk("t6_sb_empty", sb.size(), 0);
      chk("t6_drop_end", drop_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tx_pkt_buffer.md
# tx_pkt_buffer

Store-and-forward packet buffer on the transmit path, directly upstream of the router-to-MAC transmit stage. It accepts 70-bit flits from the router output port and holds each packet until its end-of-packet flit has arrived. Only then does it present the packet, back-to-back, on the `data_router`/`val`/`ack` interface, so the MAC stream never underruns mid-packet. Malformed or oversize packets are discarded and counted.

## Interface
- `DATA_WIDTH`, 70: flit width. Bit 69 = bop, bit 68 = eop, [67:4] = payload, [3:0] = byte-valid.
- `ADDR_WIDTH`, 4: buffer depth is 2^ADDR_WIDTH flits (16).
- `CNT_WIDTH`, 16: drop counter width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  DATA_WIDTH  flit from the router output port.
- `in_val`  in  1  `in_data` valid.
- `in_ready`  out  1  flit is accepted on a cycle with `in_val & in_ready`.
- `data_router`  out  DATA_WIDTH  head flit, to the transmit stage.
- `val`  out  1  head flit belongs to a fully stored packet.
- `ack`  in  1  head flit is consumed on a cycle with `val & ack`.
- `drop_cnt`  out  CNT_WIDTH  packets discarded; saturates at all-ones.

## Operation
- Storage is a circular flit RAM addressed by three pointers:
  - `rd_ptr`: head of the buffer.
  - `wr_ptr`: next write, speculative.
  - `commit_ptr`: end of the last complete packet.
- Pointers are ADDR_WIDTH+1 bits; the MSB is used for full/empty.
  - full = (`wr_ptr` − `rd_ptr`) == 2^ADDR_WIDTH.
- `pkt_count` (ADDR_WIDTH+1 bits) holds the number of complete packets stored.
- Write-side FSM:
  - **IDLE**:
    - Flit with bop=1: written. eop=1 → commit and stay in IDLE; eop=0 → go to PKT.
    - Flit with bop=0: accepted and discarded, not counted.
  - **PKT**:
    - Flit with bop=0: written. eop=1 → commit and go to IDLE.
    - Flit with bop=1 (missing eop): `wr_ptr` is rolled back to `commit_ptr`, `drop_cnt`+1, and the new flit is written at `commit_ptr`. State remains PKT, or commits if that flit also has eop=1.
    - Overflow (full with `pkt_count`==0, flit offered): `wr_ptr` ← `commit_ptr`, `drop_cnt`+1, go to DROP. The offered flit is discarded.
  - **DROP**: accept and discard everything. An eop=1 flit → IDLE. A bop=1 flit is handled as in IDLE.
- Commit: `commit_ptr` ← `wr_ptr`+1 and `pkt_count`+1.
- `in_ready`:
  - DROP: 1.
  - IDLE: !full.
  - PKT: !full | (`pkt_count`==0).
- Read side:
  - `val` = (`pkt_count` != 0).
  - `data_router` = RAM[`rd_ptr`] (asynchronous read). It is all-zero whenever `val`=0.
  - On `val & ack`, `rd_ptr`+1. If the head flit has eop=1, `pkt_count`−1.
- If `pkt_count` increments and decrements in the same cycle, it is unchanged.
- A write while full is never performed, even if a read occurs in the same cycle.

## Timing
- Reset state:
  - FSM = IDLE.
  - All pointers and `pkt_count` = 0.
  - `drop_cnt` = 0, `val` = 0, `data_router` = 0.
  - `in_ready` = 1.
  - RAM contents are not reset.
- Reset assertion mid-packet discards all stored data immediately (asynchronous reset).
- Cut-through latency is zero: if eop is written at edge N, `val` = 1 in the cycle after N.
- Once `val` rises, it stays high for every flit of that packet while `ack` is held high. The packet streams one flit per cycle.
- `ack` may be held high continuously. Consumption is counted only when `val` = 1.
- `in_ready` is combinational from registered state only. It never depends on `in_val` or `ack`.

## Structure
- Shared package `router_pkg` holds:
  - Flit field constants: BOP_BIT=69, EOP_BIT=68, DATA_MSB=67, DATA_LSB=4, VALID_MSB=3.
  - FSM encodings: IDLE, PKT, DROP.
- Sub-module `flit_ram`: simple dual-port RAM, DATA_WIDTH × 2^ADDR_WIDTH, one synchronous write port and one asynchronous read port.
- All pointer and FSM logic lives in `tx_pkt_buffer`.

## Test plan
- **Single-flit packet.** Drive bop=1, eop=1, payload 64'hA5A5_0000_0000_5A5A, valid=4'hF. Expect:
  - `val`=1 the next cycle, `data_router` equal to the flit.
  - After one `ack`, `val`=0 and `pkt_count`=0.
- **Store-and-forward.** Drive a 4-flit packet at 1 flit per cycle. Expect:
  - `val`=0 until the cycle after the eop write.
  - With `ack` held high, 4 consecutive flits out in order, then `val`=0.
- **Missing eop.** Drive 2 flits of packet A (no eop), then a 3-flit packet B. Expect:
  - Only B is output.
  - `drop_cnt`=1.
- **Overflow.** With the buffer empty, drive a 20-flit packet (depth 16). Expect:
  - `in_ready` stays 1 throughout; DROP state is entered at flit 17.
  - No `val` is asserted and `drop_cnt`=1.
  - A following 2-flit packet is delivered intact.
- **Backpressure.** Fill with complete packets, then hold `ack`=0. Expect:
  - `in_ready`=0 when full.
  - After raising `ack`, `in_ready` returns to 1 once space frees, and no flit is lost.
- **Reset mid-packet.** Assert `rst` while `val`=1 and mid-write. Expect:
  - `val`=0, `data_router`=0, `drop_cnt`=0 immediately, without waiting for a clock edge.
  - Normal operation on the next packet.
